// File: rtl/mem_access_pkg.sv
// Shared definitions for the RV32I memory stage: aluop encodings, constants,
// FSM state encoding and decode helpers for load/store ops.
package mem_access_pkg;

  localparam int MA_XLEN  = 32;
  localparam int MA_AOP_W = 5;

  typedef logic [MA_AOP_W-1:0] alu_op_bus_t;

  localparam alu_op_bus_t EX_NOP = 5'd0;
  localparam alu_op_bus_t EX_ADD = 5'd1;
  localparam alu_op_bus_t EX_SUB = 5'd2;
  localparam alu_op_bus_t EX_AND = 5'd3;
  localparam alu_op_bus_t EX_OR  = 5'd4;
  localparam alu_op_bus_t EX_XOR = 5'd5;
  localparam alu_op_bus_t EX_LB  = 5'd16;
  localparam alu_op_bus_t EX_LH  = 5'd17;
  localparam alu_op_bus_t EX_LW  = 5'd18;
  localparam alu_op_bus_t EX_LBU = 5'd19;
  localparam alu_op_bus_t EX_LHU = 5'd20;
  localparam alu_op_bus_t EX_SB  = 5'd21;
  localparam alu_op_bus_t EX_SH  = 5'd22;
  localparam alu_op_bus_t EX_SW  = 5'd23;

  localparam logic [MA_XLEN-1:0] ZERO_WORD    = '0;
  localparam logic [4:0]         NOP_REG_ADDR = 5'd0;
  localparam logic               TRUE         = 1'b1;
  localparam logic               FALSE        = 1'b0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_e;

  function automatic logic is_load(input alu_op_bus_t op);
    return (op == EX_LB) || (op == EX_LH) || (op == EX_LW) ||
           (op == EX_LBU) || (op == EX_LHU);
  endfunction

  function automatic logic is_store(input alu_op_bus_t op);
    return (op == EX_SB) || (op == EX_SH) || (op == EX_SW);
  endfunction

  function automatic logic is_mem(input alu_op_bus_t op);
    return is_load(op) || is_store(op);
  endfunction

  // Index of the final byte of the transfer (byte count minus one).
  function automatic logic [1:0] last_idx(input alu_op_bus_t op);
    case (op)
      EX_LH, EX_LHU, EX_SH: return 2'd1;
      EX_LW, EX_SW:         return 2'd3;
      default:              return 2'd0;
    endcase
  endfunction

  function automatic logic is_misaligned(input alu_op_bus_t op, input logic [1:0] a);
    case (op)
      EX_LH, EX_LHU, EX_SH: return a[0] != 1'b0;
      EX_LW, EX_SW:         return a != 2'b00;
      default:              return FALSE;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_load_ext.sv
// Combinational load assembler: little-endian byte buffer to a sign- or
// zero-extended register value according to the load op.
module mem_access_load_ext
  import mem_access_pkg::*;
#(
  parameter int XLEN = MA_XLEN
) (
  input  logic [MA_AOP_W-1:0] op,
  input  logic [3:0][7:0]     byte_buf,
  output logic [XLEN-1:0]     value
);

  always_comb begin
    value = '0;
    case (op)
      EX_LB:   value = {{(XLEN-8){byte_buf[0][7]}}, byte_buf[0]};
      EX_LBU:  value = {{(XLEN-8){1'b0}}, byte_buf[0]};
      EX_LH:   value = {{(XLEN-16){byte_buf[1][7]}}, byte_buf[1], byte_buf[0]};
      EX_LHU:  value = {{(XLEN-16){1'b0}}, byte_buf[1], byte_buf[0]};
      EX_LW:   value = XLEN'(byte_buf);
      default: value = '0;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// RV32I memory stage: byte-serial loads/stores on the memory-controller port,
// one-cycle pass-through for other ops. Build option: MEM_ALIGN_CHK_EN.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int XLEN  = MA_XLEN,
  parameter int AOP_W = MA_AOP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic [AOP_W-1:0] aluop_i,
  input  logic [XLEN-1:0]  mem_addr_i,
  input  logic [XLEN-1:0]  w_data_i,
  input  logic [4:0]       w_addr_i,
  input  logic             w_req_i,
  output logic             mc_req_o,
  output logic             mc_we_o,
  output logic [XLEN-1:0]  mc_addr_o,
  output logic [7:0]       mc_dout_o,
  input  logic             mc_ack_i,
  input  logic [7:0]       mc_din_i,
  output logic             stall_o,
  output logic [4:0]       w_addr_o,
  output logic             w_req_o,
  output logic [XLEN-1:0]  w_data_o,
  output logic             err_o,
  output mem_state_e       dbg_state
);

  // Handshake: mc_req_o is held with a stable address/data until mc_ack_i is
  // seen with rdy=1; that cycle transfers one byte (read data valid the same
  // cycle). stall_o=0 means upstream advances at the coming edge.

  mem_state_e       state_q;
  logic [1:0]       idx_q;
  logic [AOP_W-1:0] op_q;
  logic [XLEN-1:0]  addr_q;
  logic [XLEN-1:0]  data_q;
  logic [4:0]       waddr_q;
  logic             wreq_q;
  logic [3:0][7:0]  buf_q;
  logic [3:0][7:0]  buf_next;
  logic [XLEN-1:0]  ext_val;
  logic             misaligned;
  logic             start_mem;
  logic             final_ack;

`ifdef MEM_ALIGN_CHK_EN
  logic err_q;
  assign misaligned = is_mem(aluop_i) && is_misaligned(aluop_i, mem_addr_i[1:0]);
  assign err_o      = err_q;
`else
  assign misaligned = FALSE;
  assign err_o      = FALSE;
`endif

  assign start_mem = is_mem(aluop_i) && !misaligned;
  assign final_ack = rdy && (state_q == BUSY) && mc_ack_i && (idx_q == last_idx(op_q));
  assign stall_o   = ((state_q == IDLE) && start_mem && rdy) ||
                     ((state_q == BUSY) && !final_ack);

  assign mc_req_o  = rdy && (state_q == BUSY);
  assign mc_we_o   = (state_q == BUSY) && is_store(op_q);
  assign mc_addr_o = addr_q + {{(XLEN-2){1'b0}}, idx_q};
  assign mc_dout_o = data_q[{idx_q, 3'b000} +: 8];
  assign dbg_state = state_q;

  // Final byte is merged in combinationally so the result registers on the ack edge.
  always_comb begin
    buf_next        = buf_q;
    buf_next[idx_q] = mc_din_i;
  end

  mem_access_load_ext #(.XLEN(XLEN)) u_load_ext (
    .op       (op_q),
    .byte_buf (buf_next),
    .value    (ext_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      op_q     <= EX_NOP;
      addr_q   <= ZERO_WORD;
      data_q   <= ZERO_WORD;
      waddr_q  <= NOP_REG_ADDR;
      wreq_q   <= FALSE;
      buf_q    <= '0;
      w_addr_o <= NOP_REG_ADDR;
      w_req_o  <= FALSE;
      w_data_o <= ZERO_WORD;
`ifdef MEM_ALIGN_CHK_EN
      err_q    <= FALSE;
`endif
    end else if (rdy) begin
`ifdef MEM_ALIGN_CHK_EN
      err_q <= FALSE;
`endif
      case (state_q)
        IDLE: begin
          if (start_mem) begin
            op_q    <= aluop_i;
            addr_q  <= mem_addr_i;
            data_q  <= w_data_i;
            waddr_q <= w_addr_i;
            wreq_q  <= w_req_i;
            idx_q   <= 2'd0;
            state_q <= BUSY;
            w_req_o <= FALSE;
          end else if (misaligned) begin
            w_req_o <= FALSE;
`ifdef MEM_ALIGN_CHK_EN
            err_q   <= TRUE;
`endif
          end else begin
            w_addr_o <= w_addr_i;
            w_req_o  <= w_req_i;
            w_data_o <= w_data_i;
          end
        end
        BUSY: begin
          w_req_o <= FALSE;
          if (mc_ack_i) begin
            if (is_load(op_q)) buf_q[idx_q] <= mc_din_i;
            idx_q <= idx_q + 2'd1;
            if (final_ack) begin
              state_q <= IDLE;
              idx_q   <= 2'd0;
              if (is_load(op_q)) begin
                w_addr_o <= waddr_q;
                w_req_o  <= wreq_q;
                w_data_o <= ext_val;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
